// File: rtl/mem_line_packer_pkg.sv
// Shared element-width define and width-conversion helpers for the narrow/wide gather and scatter stages.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package mem_line_packer_pkg;

    localparam int ELEM_W = `DATA_WIDTH;

    // Guarded so that a bad parameter set still elaborates far enough to report the error.
    function automatic int conv_ratio(input int narrow_w, input int wide_w);
        return (narrow_w > 0) ? (wide_w / narrow_w) : 1;
    endfunction

    function automatic int conv_cnt_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/mem_line_packer.sv
// Gathers RATIO narrow beats into one element-packed line for the memory wiring stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_line_packer
    import mem_line_packer_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 256,
    localparam int RATIO    = conv_ratio(IN_WIDTH, OUT_WIDTH),
    localparam int CNT_W    = conv_cnt_w(RATIO)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ELEM_W*IN_WIDTH-1:0]    in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ELEM_W*OUT_WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]              out_beats
);

    localparam int BEAT_W = ELEM_W * IN_WIDTH;
    localparam int LINE_W = ELEM_W * OUT_WIDTH;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    if (OUT_WIDTH % IN_WIDTH != 0) begin : g_bad_ratio
        $error("mem_line_packer: OUT_WIDTH must be a multiple of IN_WIDTH");
    end

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic [LINE_W-1:0] line_q, line_d;

    logic accept;
    logic emit;
    logic closing;

    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign closing   = accept && ((idx_q == CNT_W'(RATIO - 1)) || in_last);

    assign out_data  = line_q;
    assign out_beats = beats_q;

    always_comb begin
        line_d  = line_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        if (accept) begin
            // A fresh line starts clean so slots past an early close read as zero.
            if (idx_q == '0) begin
                line_d = '0;
            end
            line_d[idx_q*BEAT_W +: BEAT_W] = in_data;
            if (closing) begin
                idx_d   = '0;
                beats_d = idx_q + CNT_W'(1);
            end else begin
                idx_d   = idx_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (closing)          state_d = ST_HOLD;
            ST_HOLD: if (emit && !closing) state_d = ST_FILL;
            default:                       state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            beats_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: tb/tb_mem_line_packer.sv
// Directed scoreboard bench for mem_line_packer (default 32->256 and a 32->32 instance).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_mem_line_packer;
    import mem_line_packer_pkg::*;

    localparam int IN_W   = 32;
    localparam int OUT_W  = 256;
    localparam int RATIO  = conv_ratio(IN_W, OUT_W);
    localparam int CNT_W  = conv_cnt_w(RATIO);
    localparam int CNT1_W = conv_cnt_w(1);
    localparam int BEAT_W = ELEM_W * IN_W;
    localparam int LINE_W = ELEM_W * OUT_W;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [CNT_W-1:0]  beats;
    } line_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid, in_ready, in_last;
    logic [BEAT_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [LINE_W-1:0] out_data;
    logic [CNT_W-1:0]  out_beats;

    logic              in1_valid, in1_ready, in1_last;
    logic [BEAT_W-1:0] in1_data;
    logic              out1_valid, out1_ready;
    logic [BEAT_W-1:0] out1_data;
    logic [CNT1_W-1:0] out1_beats;

    line_t             sb[$];
    logic [LINE_W-1:0] m_line;
    int                m_idx;
    int                n_cmp = 0;
    int                n_bad = 0;

    mem_line_packer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats)
    );

    mem_line_packer #(.IN_WIDTH(IN_W), .OUT_WIDTH(IN_W)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data), .in_last(in1_last),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data), .out_beats(out1_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        int first;
        first = 0;
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            for (int g = OUT_W - 1; g >= 0; g--)
                if (obs[g*ELEM_W +: ELEM_W] !== exp[g*ELEM_W +: ELEM_W]) first = g;
            $error("FAIL %s: element %0d observed %0h expected %0h", tag, first,
                   obs[first*ELEM_W +: ELEM_W], exp[first*ELEM_W +: ELEM_W]);
        end
    endtask

    function automatic logic [BEAT_W-1:0] seq_beat(input int base);
        logic [BEAT_W-1:0] b;
        for (int e = 0; e < IN_W; e++) b[e*ELEM_W +: ELEM_W] = ELEM_W'(base + e);
        return b;
    endfunction

    function automatic logic [BEAT_W-1:0] fill_beat(input logic [ELEM_W-1:0] v);
        logic [BEAT_W-1:0] b;
        for (int e = 0; e < IN_W; e++) b[e*ELEM_W +: ELEM_W] = v;
        return b;
    endfunction

    // Offers one beat until accepted; updates the reference line and queues closed lines.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic last, output int waits);
        bit    got;
        line_t e;
        got   = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else          waits++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $error("FAIL accept_timeout: observed in_ready low for %0d cycles expected accept", waits);
        end else begin
            if (m_idx == 0) m_line = '0;
            m_line[m_idx*BEAT_W +: BEAT_W] = d;
            if (m_idx == RATIO - 1 || last) begin
                e.data  = m_line;
                e.beats = CNT_W'(m_idx + 1);
                sb.push_back(e);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL emit_unexpected: observed line with out_beats %0d expected no line", out_beats);
            end else begin
                line_t e;
                e = sb.pop_front();
                check_line("emit_data", out_data, e.data);
                check("emit_beats", 64'(out_beats), 64'(e.beats));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish expected finish before 50000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int                w;
        logic [LINE_W-1:0] snap;
        logic [BEAT_W-1:0] r;

        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        in1_valid = 1'b0; in1_last = 1'b0; in1_data = '0; out1_ready = 1'b1;
        m_line = '0;
        m_idx  = 0;

        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_beats", 64'(out_beats), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check_line("rst_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full line of global element indices 0..255.
        for (int k = 0; k < RATIO; k++) begin
            send_beat(seq_beat(k * IN_W), 1'b0, w);
            if (k == RATIO - 2) check("full_not_early", 64'(out_valid), 64'd0);
        end
        check("full_latency", 64'(out_valid), 64'd1);
        check("full_beats", 64'(out_beats), 64'(RATIO));

        // Early close after three beats; first beat accepted while the full line emits.
        for (int k = 0; k < 3; k++) send_beat(fill_beat(ELEM_W'(8'hA0 + k)), k == 2, w);
        check("early_latency", 64'(out_valid), 64'd1);
        check("early_beats", 64'(out_beats), 64'd3);
        check("early_tail_zero", 64'(|out_data[LINE_W-1:3*BEAT_W]), 64'd0);
        idle(2);

        // Backpressure: complete line held for five cycles with a garbage beat offered.
        out_ready = 1'b0;
        for (int k = 0; k < RATIO; k++) send_beat(seq_beat(8'h30 + 3 * k), 1'b0, w);
        check("hold_valid", 64'(out_valid), 64'd1);
        snap = out_data;
        in_valid = 1'b1;
        in_data  = fill_beat(ELEM_W'(8'hEE));
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_beats", 64'(out_beats), 64'(RATIO));
            check_line("hold_data_stable", out_data, snap);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_beat(seq_beat(8'h11), 1'b0, w);
        check("release_same_cycle_accept", 64'(w), 64'd0);
        check("release_valid_drops", 64'(out_valid), 64'd0);
        for (int k = 1; k < RATIO; k++) send_beat(seq_beat(8'h11 + k), 1'b0, w);

        // Sustained throughput: 32 back-to-back beats, one line every RATIO cycles.
        for (int i = 0; i < 4 * RATIO; i++) begin
            send_beat(seq_beat(5 * i), 1'b0, w);
            check("stream_no_stall", 64'(w), 64'd0);
            check("stream_valid_cadence", 64'(out_valid), 64'((i % RATIO) == RATIO - 1));
        end

        // Reset mid-line discards the partial line.
        for (int k = 0; k < 5; k++) send_beat(fill_beat(ELEM_W'(8'hC0 + k)), 1'b0, w);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_beats", 64'(out_beats), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        m_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < RATIO; k++) send_beat(seq_beat(8'h40 + 7 * k), 1'b0, w);
        check("fresh_beats", 64'(out_beats), 64'(RATIO));
        idle(3);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        // One-beat lines: every accepted beat emitted next cycle with out_beats=1.
        in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int q = 0; q < BEAT_W / 32; q++) r[q*32 +: 32] = $urandom;
            in1_data = r;
            in1_last = 1'(i % 2);
            @(negedge clk);
            check("r1_in_ready", 64'(in1_ready), 64'd1);
            @(posedge clk);
            #1;
            check("r1_out_valid", 64'(out1_valid), 64'd1);
            check("r1_out_beats", 64'(out1_beats), 64'd1);
            n_cmp++;
            assert (out1_data === r) else begin
                n_bad++;
                $error("FAIL r1_out_data: observed %0h expected %0h", out1_data, r);
            end
        end
        in1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("r1_valid_drops", 64'(out1_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_line_packer.md
Name: mem_line_packer

Overview:
- Gather stage directly upstream of the memory wiring block.
- Accepts narrow beats of IN_WIDTH elements, each `DATA_WIDTH bits, over a valid/ready handshake.
- Assembles RATIO = OUT_WIDTH/IN_WIDTH consecutive beats into one OUT_WIDTH-element line and presents it over a valid/ready handshake.
- Its out_data has exactly the flat element-packed layout (element g at bits [`DATA_WIDTH*g +: `DATA_WIDTH]) consumed by the wiring stage.

Parameters:
- IN_WIDTH, 32: elements per input beat.
- OUT_WIDTH, 256: elements per output line. Must be an integer multiple of IN_WIDTH; RATIO = OUT_WIDTH/IN_WIDTH (default 8).
- CNT_W, $clog2(RATIO)+1 (derived localparam): width of beat counter and out_beats.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  `DATA_WIDTH*IN_WIDTH  input beat, element 0 in LSBs.
- in_last  in  1  qualified by in_valid; beat closes current line early.
- out_valid  out  1  assembled line available.
- out_ready  in  1  downstream accepts line.
- out_data  out  `DATA_WIDTH*OUT_WIDTH  assembled line.
- out_beats  out  CNT_W  number of valid beats in out_data (1..RATIO).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_beats=0, beat index=0, in_ready=1.
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- in_ready = !out_valid || out_ready. Combinational from out_valid/out_ready only, never from in_valid.
- Beat k of a line (k = beat index at accept) is written to elements [k*IN_WIDTH +: IN_WIDTH] of the line register; element order inside the beat is preserved.
- Line closes on accept when k == RATIO-1 or in_last=1:
  - out_valid=1 next cycle, out_beats=k+1, beat index returns to 0.
  - Latency: closing beat accepted in cycle N produces out_valid in cycle N+1.
- First beat of a new line (index 0) clears all slots other than slot 0, so slots beyond out_beats are zero after an early close.
- While out_valid && !out_ready: out_data and out_beats are held stable and in_ready=0 (no accepts).
- Emit and accept in the same cycle: out_valid drops unless the accepted beat itself closes a line (possible only when in_last=1 or RATIO=1), in which case out_valid stays 1 with new contents. The new beat starts a fresh line. Sustained full throughput: one line per RATIO cycles, no bubbles.
- in_last with k == RATIO-1: single close, out_beats=RATIO.
- RATIO=1: every accepted beat closes a line, out_beats=1.
- Reset mid-line or mid-hold: partial/pending line is discarded, no output.
- Inputs are ignored when in_ready=0; in_last is ignored unless accepted.
- out_beats arithmetic is unsigned, width CNT_W, never wraps (max RATIO).
- State: FILL (out_valid=0, collecting) and HOLD (out_valid=1).
  - FILL -> HOLD on a closing accept.
  - HOLD -> FILL on emit without a closing accept.
  - HOLD -> HOLD on no emit, or on emit together with a closing accept.

Decomposition:
- `DATA_WIDTH stays in the shared defines header.
- Shared package/header gains the RATIO and CNT_W derivation helper and an element-slice width constant, reused by other width-conversion stages.
- No sub-module: counter, line register and control are in one module (about 150 RTL lines).
- Elaboration check: OUT_WIDTH % IN_WIDTH == 0, else $error.

Test Plan:
- Reset release, then 8 beats with element value = global index 0..255 and out_ready=1 -> cycle after 8th accept: out_valid=1, out_data element g = g, out_beats=8.
- 3 beats, third with in_last=1, data 0xA.. pattern -> out_beats=3, elements 96..255 = 0, out_valid one cycle after third accept.
- Line complete and out_ready=0 for 5 cycles -> in_ready=0, out_data stable for all 5 cycles; raising out_ready emits once, and the first beat of the next line is accepted in the same cycle.
- Continuous 32 beats, in_valid=1, out_ready=1 -> 4 lines, no idle cycle on in_ready, out_valid pulses every 8 cycles.
- rst_n asserted after 5 beats of a line, then 8 fresh beats -> only the fresh line appears, out_beats=8, no stale data.
- Parameter override IN_WIDTH=OUT_WIDTH=32 -> each beat emitted the next cycle with out_beats=1.
